// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states and
// small decode helpers used by control and hazard logic.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned iteration core: operand magnitudes and result
// signs on the way in, negation and divide-by-zero override on the way out.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] abs_a_o,
    output logic [WIDTH-1:0] abs_b_o,
    output logic             neg_lo_o,
    output logic             neg_hi_o,
    output logic             dbz_o,
    input  logic             is_div_i,
    input  logic             neg_lo_i,
    input  logic             neg_hi_i,
    input  logic             dbz_i,
    input  logic [WIDTH-1:0] raw_hi_i,
    input  logic [WIDTH-1:0] raw_lo_i,
    output logic [WIDTH-1:0] fix_hi_o,
    output logic [WIDTH-1:0] fix_lo_o
);

    logic                   sign_a;
    logic                   sign_b;
    logic [2*WIDTH-1:0]     prod_raw;
    logic [2*WIDTH-1:0]     prod_fix;

    always_comb begin
        sign_a   = op_is_signed(op_i) & a_i[WIDTH-1];
        sign_b   = op_is_signed(op_i) & b_i[WIDTH-1];
        abs_a_o  = sign_a ? -a_i : a_i;
        abs_b_o  = sign_b ? -b_i : b_i;
        neg_lo_o = sign_a ^ sign_b;
        // Remainder follows the dividend; a product's upper half follows the product.
        neg_hi_o = op_is_div(op_i) ? sign_a : (sign_a ^ sign_b);
        dbz_o    = op_is_div(op_i) && (b_i == '0);
    end

    always_comb begin
        prod_raw = {raw_hi_i, raw_lo_i};
        prod_fix = neg_lo_i ? -prod_raw : prod_raw;
        fix_hi_o = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo_o = prod_fix[WIDTH-1:0];
        if (is_div_i) begin
            // Remainder of x/0 is |x|, re-signed by the dividend, which is x itself.
            fix_hi_o = neg_hi_i ? -raw_hi_i : raw_hi_i;
            fix_lo_o = dbz_i ? '1 : (neg_lo_i ? -raw_lo_i : raw_lo_i);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers; one
// shift-add or restoring-divide step per cycle, fixed WIDTH+2 cycle latency.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    op_e              op_in;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             pre_neg_lo, pre_neg_hi, pre_dbz;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    assign op_in = op_e'(op);

    muldiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .op_i     (op_in),
        .a_i      (a),
        .b_i      (b),
        .abs_a_o  (abs_a),
        .abs_b_o  (abs_b),
        .neg_lo_o (pre_neg_lo),
        .neg_hi_o (pre_neg_hi),
        .dbz_o    (pre_dbz),
        .is_div_i (is_div_q),
        .neg_lo_i (neg_lo_q),
        .neg_hi_i (neg_hi_q),
        .dbz_i    (dbz_q),
        .raw_hi_i (acc_hi_q),
        .raw_lo_i (acc_lo_q),
        .fix_hi_o (fix_hi),
        .fix_lo_o (fix_lo)
    );

    // acc_lo holds the multiplier (shifted out) or the dividend/quotient (shifted through).
    always_comb begin
        add_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            iter_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            iter_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            iter_hi = add_sum[WIDTH:1];
            iter_lo = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_d    = dbz_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_hi) hi_d = wdata;
                if (wr_lo) lo_d = wdata;
                if (start) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    is_div_d = op_is_div(op_in);
                    neg_lo_d = pre_neg_lo;
                    neg_hi_d = pre_neg_hi;
                    dbz_d    = pre_dbz;
                    acc_hi_d = '0;
                    acc_lo_d = abs_a;
                    opnd_d   = abs_b;
                end
            end
            StCalc: begin
                acc_hi_d = iter_hi;
                acc_lo_d = iter_lo;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results plus a
// randomized run compared every cycle against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: architectural HI/LO, edges left until the result lands.
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_rem = 0;
    logic         m_done = 1'b0;

    muldiv_unit #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, output logic [W-1:0] h,
                                   output logic [W-1:0] l);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        h  = '0;
        l  = '0;
        case (o)
            2'd0: begin
                sq = sx * sy;
                {h, l} = sq;
            end
            2'd1: begin
                uq = ux * uy;
                {h, l} = uq;
            end
            default: begin
                if (y == '0) begin
                    l = '1;
                    h = x;
                end else if (o == 2'd2) begin
                    sq = sx / sy;
                    sr = sx % sy;
                    l  = sq[W-1:0];
                    h  = sr[W-1:0];
                end else begin
                    uq = ux / uy;
                    ur = ux % uy;
                    l  = uq[W-1:0];
                    h  = ur[W-1:0];
                end
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_hi   = '0;
            m_lo   = '0;
            m_rem  = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                end
            end else begin
                if (wr_hi) m_hi = wdata;
                if (wr_lo) m_lo = wdata;
                if (start) begin
                    ref_op(op, a, b, p_hi, p_lo);
                    m_rem = W + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_rem > 0));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the sampling edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    logic [W-1:0] rh, rl;
    int           cyc, ndone;

    initial begin
        ref_op(2'd0, 32'hffff_fffd, 32'h0000_0005, rh, rl);
        chk("model_mult", {rh, rl}, 64'hffff_ffff_ffff_fff1);
        ref_op(2'd2, 32'hffff_fff9, 32'h0000_0002, rh, rl);
        chk("model_div", {rh, rl}, 64'hffff_ffff_ffff_fffd);
        ref_op(2'd2, 32'h8000_0000, 32'hffff_ffff, rh, rl);
        chk("model_div_ovf", {rh, rl}, 64'h0000_0000_8000_0000);
        ref_op(2'd3, 32'h0000_0007, 32'h0000_0000, rh, rl);
        chk("model_dbz", {rh, rl}, 64'h0000_0007_ffff_ffff);

        repeat (3) @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        issue(2'd0, 32'hffff_fffd, 32'h0000_0005);
        wait_done(cyc);
        chk("mult_latency", 64'(cyc), 64'd34);
        chk("mult_hilo", {hi, lo}, 64'hffff_ffff_ffff_fff1);

        issue(2'd1, 32'hffff_ffff, 32'hffff_ffff);
        wait_done(cyc);
        chk("multu_hilo", {hi, lo}, 64'hffff_fffe_0000_0001);
        issue(2'd2, 32'hffff_fff9, 32'h0000_0002);
        wait_done(cyc);
        chk("b2b_latency", 64'(cyc), 64'd34);
        chk("div_hilo", {hi, lo}, 64'hffff_ffff_ffff_fffd);

        @(negedge clk);
        issue(2'd3, 32'h0000_0007, 32'h0000_0000);
        wait_done(cyc);
        chk("divu_dbz_hilo", {hi, lo}, 64'h0000_0007_ffff_ffff);
        @(negedge clk);
        issue(2'd2, 32'h8000_0000, 32'hffff_ffff);
        wait_done(cyc);
        chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        @(negedge clk);
        issue(2'd1, 32'hffff_ffff, 32'hffff_ffff);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        issue(2'd1, 32'h0000_0002, 32'h0000_0003);
        wr_hi = 1'b1;
        wdata = 32'h1234_5678;
        start = 1'b1;
        a     = 32'h0000_0009;
        @(negedge clk);
        wr_hi = 1'b0;
        start = 1'b0;
        chk("busy_write_ignored", 64'(hi), 64'd0);
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("single_done", 64'(ndone), 64'd1);
        chk("multu_small_hilo", {hi, lo}, 64'h0000_0000_0000_0006);
        wr_hi = 1'b1;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("idle_write", 64'(hi), 64'h1234_5678);

        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            a     = rnd_opnd();
            b     = rnd_opnd();
            wr_hi = ($urandom_range(0, 7) == 0);
            wr_lo = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            reset = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        reset = 1'b1;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
